// File: rtl/pixel_gain.sv
// Multi-channel fixed-point gain with per-channel saturation, 2-stage pipeline,
// and press-and-hold auto-repeat level control; sideband is delayed to match.
module pixel_gain #(
  parameter int CH_W    = 8,
  parameter int NUM_CH  = 3,
  parameter int LVL_W   = 4,
  parameter int FRAC_W  = 3,
  parameter int PASS_W  = 24,
  parameter int RPT_DLY = 1000000,
  parameter int RPT_PER = 250000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   dec,
  input  logic [NUM_CH-1:0]      ch_mask,
  input  logic                   in_valid,
  input  logic [NUM_CH*CH_W-1:0] pixel_in,
  input  logic [PASS_W-1:0]      pass_in,
  output logic                   out_valid,
  output logic [NUM_CH*CH_W-1:0] pixel_out,
  output logic [PASS_W-1:0]      pass_thru,
  output logic [LVL_W-1:0]       level_out
);

  localparam int P_W     = CH_W + LVL_W;
  localparam int Y_W     = P_W - FRAC_W;
  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);

  localparam logic [LVL_W-1:0] UNITY    = LVL_W'(1 << FRAC_W);
  localparam logic [LVL_W-1:0] LVL_MAX  = '1;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PER - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             dir_reg, dir_next;
  logic             req, dir, step;

  assign req = inc ^ dec;
  assign dir = inc;

  // Any change in the request while held drops back to IDLE without stepping.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    step       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          step       = 1'b1;
          cnt_next   = '0;
          dir_next   = dir;
          state_next = S_HOLD;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!req || (dir != dir_reg)) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == ((state_reg == S_HOLD) ? DLY_LAST : PER_LAST)) begin
          step       = 1'b1;
          cnt_next   = '0;
          state_next = S_REPEAT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    level_next = level_reg;
    if (step) begin
      if (dir && (level_reg != LVL_MAX))
        level_next = level_reg + 1'b1;
      else if (!dir && (level_reg != '0))
        level_next = level_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      level_reg <= UNITY;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      dir_reg   <= dir_next;
    end
  end

  assign level_out = level_reg;

  // Stage 1 keeps the raw sample so masked-off channels can bypass the gain.
  logic [NUM_CH-1:0][P_W-1:0]  prod_next, prod_reg;
  logic [NUM_CH-1:0][CH_W-1:0] raw_reg;
  logic [NUM_CH-1:0]           mask_reg;
  logic                        valid1_reg;
  logic [PASS_W-1:0]           pass1_reg;
  logic [NUM_CH*CH_W-1:0]      chan_out;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [Y_W-1:0] y;
      logic           over;
      assign prod_next[gi] = P_W'(pixel_in[gi*CH_W +: CH_W]) * P_W'(level_reg);
      assign y    = prod_reg[gi][P_W-1:FRAC_W];
      assign over = |y[Y_W-1:CH_W];
      assign chan_out[gi*CH_W +: CH_W] = !mask_reg[gi] ? raw_reg[gi] :
                                         over ? {CH_W{1'b1}} : y[CH_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_reg   <= '0;
      raw_reg    <= '0;
      mask_reg   <= '0;
      valid1_reg <= 1'b0;
      pass1_reg  <= '0;
      out_valid  <= 1'b0;
      pixel_out  <= '0;
      pass_thru  <= '0;
    end else begin
      prod_reg   <= prod_next;
      raw_reg    <= pixel_in;
      mask_reg   <= ch_mask;
      valid1_reg <= in_valid;
      pass1_reg  <= pass_in;
      out_valid  <= valid1_reg;
      pixel_out  <= chan_out;
      pass_thru  <= pass1_reg;
    end
  end

endmodule
